// File: rtl/vram_write_arbiter_if.sv
// Write-side bus of the video RAM arbiter: CPU strobe, keyboard valid/ready,
// clear control and the registered video RAM write port.
interface vram_write_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 3
);
  logic              cpuWrite;
  logic [ADDR_W-1:0] cpuAddr;
  logic [DATA_W-1:0] cpuColor;
  logic              cpuOverflow;
  logic              kbValid;
  logic [ADDR_W-1:0] kbAddr;
  logic [DATA_W-1:0] kbColor;
  logic              kbReady;
  logic              clearStart;
  logic              clearBusy;
  logic              writeEnable;
  logic [ADDR_W-1:0] writeAddress;
  logic [DATA_W-1:0] dataIn;

  modport master (
    output cpuWrite, cpuAddr, cpuColor, kbValid, kbAddr, kbColor, clearStart,
    input  cpuOverflow, kbReady, clearBusy, writeEnable, writeAddress, dataIn
  );

  modport slave (
    input  cpuWrite, cpuAddr, cpuColor, kbValid, kbAddr, kbColor, clearStart,
    output cpuOverflow, kbReady, clearBusy, writeEnable, writeAddress, dataIn
  );
endinterface

// File: rtl/vram_write_arbiter.sv
// Owns the video RAM write port: buffered CPU writes and keyboard writes served round-robin.
// Optional full-screen clear sweep is built when VRAM_CLEAR_EN is defined.
module vram_write_arbiter #(
  parameter int                ADDR_W         = 16,
  parameter int                DATA_W         = 3,
  parameter int                CPU_FIFO_DEPTH = 4,
  parameter int                MEM_DEPTH      = 39936,
  parameter logic [DATA_W-1:0] CLEAR_COLOR    = '0
) (
  input logic                clk,
  input logic                rst_n,
  vram_write_arbiter_if.slave bus
);

  localparam int              PTR_W      = $clog2(CPU_FIFO_DEPTH);
  localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W+1)'(CPU_FIFO_DEPTH);

  logic [ADDR_W-1:0] fifoAddr  [CPU_FIFO_DEPTH];
  logic [DATA_W-1:0] fifoColor [CPU_FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W:0]    count;

  logic              lastWasKb;
  logic              overflow;
  logic              clearing;
  logic [ADDR_W-1:0] clearAddr;

  logic              fifoEmpty;
  logic              cpuCand;
  logic              kbCand;
  logic              grantCpu;
  logic              grantKb;
  logic              pushOk;
  logic              pushDrop;

  logic              weReg;
  logic [ADDR_W-1:0] addrReg;
  logic [DATA_W-1:0] dataReg;

`ifdef VRAM_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} clearState_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  clearState_t       state;
  logic [ADDR_W-1:0] clearCnt;

  // Sweep walks every word once; a start request during a sweep is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      clearCnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clearStart) begin
            state    <= CLEAR;
            clearCnt <= '0;
          end
        end
        CLEAR: begin
          if (clearCnt == LAST_ADDR) begin
            state <= IDLE;
          end
          clearCnt <= clearCnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign clearing      = (state == CLEAR);
  assign clearAddr     = clearCnt;
  assign bus.clearBusy = clearing;
`else
  logic unusedClearStart;

  assign unusedClearStart = bus.clearStart;
  assign clearing         = 1'b0;
  assign clearAddr        = '0;
  assign bus.clearBusy    = 1'b0;
`endif

  assign fifoEmpty = (count == '0);
  assign cpuCand   = !fifoEmpty && !clearing;
  assign kbCand    = bus.kbValid && !clearing;

  // On contention the requester that was not served last wins.
  assign grantCpu = cpuCand && (!kbCand || lastWasKb);
  assign grantKb  = kbCand && (!cpuCand || !lastWasKb);

  assign pushOk   = bus.cpuWrite && ((count != FULL_COUNT) || grantCpu);
  assign pushDrop = bus.cpuWrite && !pushOk;

  always_ff @(posedge clk) begin
    if (pushOk) begin
      fifoAddr[wrPtr]  <= bus.cpuAddr;
      fifoColor[wrPtr] <= bus.cpuColor;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      lastWasKb <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      if (pushOk) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (grantCpu) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({pushOk, grantCpu})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (grantCpu) begin
        lastWasKb <= 1'b0;
      end else if (grantKb) begin
        lastWasKb <= 1'b1;
      end
      if (pushDrop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Address and data hold their last value on idle cycles; only the enable drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weReg   <= 1'b0;
      addrReg <= '0;
      dataReg <= '0;
    end else begin
      weReg <= 1'b0;
      if (clearing) begin
        weReg   <= 1'b1;
        addrReg <= clearAddr;
        dataReg <= CLEAR_COLOR;
      end else if (grantCpu) begin
        weReg   <= 1'b1;
        addrReg <= fifoAddr[rdPtr];
        dataReg <= fifoColor[rdPtr];
      end else if (grantKb) begin
        weReg   <= 1'b1;
        addrReg <= bus.kbAddr;
        dataReg <= bus.kbColor;
      end
    end
  end

  assign bus.kbReady      = grantKb;
  assign bus.cpuOverflow  = overflow;
  assign bus.writeEnable  = weReg;
  assign bus.writeAddress = addrReg;
  assign bus.dataIn       = dataReg;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter: vector table for latency, arbitration and
// overflow, plus hand sequences for async reset and the clear sweep.
module tb_vram_write_arbiter;

  typedef struct packed {
    logic        cpuWrite;
    logic [15:0] cpuAddr;
    logic [2:0]  cpuColor;
    logic        kbValid;
    logic [15:0] kbAddr;
    logic [2:0]  kbColor;
    logic        expReady;
    logic        expWe;
    logic [15:0] expAddr;
    logic [2:0]  expData;
    logic        expOvf;
  } vec_t;

  localparam int NUM_VECS = 25;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  vec_t vecs [NUM_VECS];

  vram_write_arbiter_if #(.ADDR_W(16), .DATA_W(3)) bus ();

  vram_write_arbiter #(
    .ADDR_W(16), .DATA_W(3), .CPU_FIFO_DEPTH(4), .MEM_DEPTH(39936), .CLEAR_COLOR(3'b000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic cw, input logic [15:0] ca, input logic [2:0] cc,
                              input logic kv, input logic [15:0] ka, input logic [2:0] kc,
                              input logic er, input logic ew, input logic [15:0] ea,
                              input logic [2:0] ed, input logic eo);
    vec_t v;
    v.cpuWrite = cw; v.cpuAddr = ca; v.cpuColor = cc;
    v.kbValid = kv;  v.kbAddr = ka;  v.kbColor = kc;
    v.expReady = er; v.expWe = ew;   v.expAddr = ea; v.expData = ed; v.expOvf = eo;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    bus.cpuWrite = v.cpuWrite;
    bus.cpuAddr  = v.cpuAddr;
    bus.cpuColor = v.cpuColor;
    bus.kbValid  = v.kbValid;
    bus.kbAddr   = v.kbAddr;
    bus.kbColor  = v.kbColor;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " we"},    32'(bus.writeEnable),  32'd0);
    checkOutput({tag, " addr"},  32'(bus.writeAddress), 32'd0);
    checkOutput({tag, " data"},  32'(bus.dataIn),       32'd0);
    checkOutput({tag, " ovf"},   32'(bus.cpuOverflow),  32'd0);
    checkOutput({tag, " ready"}, 32'(bus.kbReady),      32'd0);
    checkOutput({tag, " busy"},  32'(bus.clearBusy),    32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.cpuWrite = 1'b0; bus.cpuAddr = '0; bus.cpuColor = '0;
    bus.kbValid  = 1'b0; bus.kbAddr  = '0; bus.kbColor  = '0;
    bus.clearStart = 1'b0;

    // Rows 10..18 strobe CPU write i to 0x1000+i, colour i+1, against a busy keyboard.
    vecs[0]  = mk(0, 16'h0000, 3'd0, 0, 16'h0000, 3'd0, 0, 0, 16'h0000, 3'd0, 0);
    vecs[1]  = mk(1, 16'h0A05, 3'b101, 0, 16'h0000, 3'd0, 0, 0, 16'h0000, 3'd0, 0);
    vecs[2]  = mk(0, 16'h0000, 3'd0, 0, 16'h0000, 3'd0, 0, 0, 16'h0000, 3'd0, 0);
    vecs[3]  = mk(0, 16'h0000, 3'd0, 0, 16'h0000, 3'd0, 0, 1, 16'h0A05, 3'b101, 0);
    vecs[4]  = mk(0, 16'h0000, 3'd0, 0, 16'h0000, 3'd0, 0, 0, 16'h0A05, 3'b101, 0);
    vecs[5]  = mk(0, 16'h0000, 3'd0, 1, 16'h0001, 3'd1, 1, 0, 16'h0A05, 3'b101, 0);
    vecs[6]  = mk(0, 16'h0000, 3'd0, 1, 16'h0002, 3'd2, 1, 1, 16'h0001, 3'd1, 0);
    vecs[7]  = mk(0, 16'h0000, 3'd0, 1, 16'h0003, 3'd3, 1, 1, 16'h0002, 3'd2, 0);
    vecs[8]  = mk(0, 16'h0000, 3'd0, 0, 16'h0000, 3'd0, 0, 1, 16'h0003, 3'd3, 0);
    vecs[9]  = mk(0, 16'h0000, 3'd0, 0, 16'h0000, 3'd0, 0, 0, 16'h0003, 3'd3, 0);
    vecs[10] = mk(1, 16'h1000, 3'd1, 1, 16'h0101, 3'd7, 1, 0, 16'h0003, 3'd3, 0);
    vecs[11] = mk(1, 16'h1001, 3'd2, 1, 16'h0101, 3'd7, 0, 1, 16'h0101, 3'd7, 0);
    vecs[12] = mk(1, 16'h1002, 3'd3, 1, 16'h0101, 3'd7, 1, 1, 16'h1000, 3'd1, 0);
    vecs[13] = mk(1, 16'h1003, 3'd4, 1, 16'h0101, 3'd7, 0, 1, 16'h0101, 3'd7, 0);
    vecs[14] = mk(1, 16'h1004, 3'd5, 1, 16'h0101, 3'd7, 1, 1, 16'h1001, 3'd2, 0);
    vecs[15] = mk(1, 16'h1005, 3'd6, 1, 16'h0101, 3'd7, 0, 1, 16'h0101, 3'd7, 0);
    vecs[16] = mk(1, 16'h1006, 3'd7, 1, 16'h0101, 3'd7, 1, 1, 16'h1002, 3'd3, 0);
    vecs[17] = mk(1, 16'h1007, 3'd0, 1, 16'h0101, 3'd7, 0, 1, 16'h0101, 3'd7, 0);
    vecs[18] = mk(1, 16'h1008, 3'd1, 1, 16'h0101, 3'd7, 1, 1, 16'h1003, 3'd4, 0);
    vecs[19] = mk(0, 16'h0000, 3'd0, 1, 16'h0101, 3'd7, 0, 1, 16'h0101, 3'd7, 1);
    vecs[20] = mk(0, 16'h0000, 3'd0, 0, 16'h0000, 3'd0, 0, 1, 16'h1004, 3'd5, 1);
    vecs[21] = mk(0, 16'h0000, 3'd0, 0, 16'h0000, 3'd0, 0, 1, 16'h1005, 3'd6, 1);
    vecs[22] = mk(0, 16'h0000, 3'd0, 0, 16'h0000, 3'd0, 0, 1, 16'h1006, 3'd7, 1);
    vecs[23] = mk(0, 16'h0000, 3'd0, 0, 16'h0000, 3'd0, 0, 1, 16'h1007, 3'd0, 1);
    vecs[24] = mk(0, 16'h0000, 3'd0, 0, 16'h0000, 3'd0, 0, 0, 16'h1007, 3'd0, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < NUM_VECS; i++) begin
      @(posedge clk);
      #1 applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("v%0d ready", i), 32'(bus.kbReady),      32'(vecs[i].expReady));
      checkOutput($sformatf("v%0d we", i),    32'(bus.writeEnable),  32'(vecs[i].expWe));
      checkOutput($sformatf("v%0d addr", i),  32'(bus.writeAddress), 32'(vecs[i].expAddr));
      checkOutput($sformatf("v%0d data", i),  32'(bus.dataIn),       32'(vecs[i].expData));
      checkOutput($sformatf("v%0d ovf", i),   32'(bus.cpuOverflow),  32'(vecs[i].expOvf));
    end

    // Async reset while CPU writes are queued and overflow is still set.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 bus.cpuWrite = 1'b1; bus.cpuAddr = 16'h2000 + 16'(i); bus.cpuColor = 3'd5;
    end
    @(posedge clk);
    #1 bus.cpuWrite = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkAllZero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("postreset%0d we", i), 32'(bus.writeEnable), 32'd0);
      checkOutput($sformatf("postreset%0d ovf", i), 32'(bus.cpuOverflow), 32'd0);
    end

`ifdef VRAM_CLEAR_EN
    begin
      int          busyCycles;
      int          nextClr;
      int          kbBad;
      int          postCycles;
      bit          done;
      logic [15:0] otherAddr [$];
      logic [2:0]  otherData [$];
      busyCycles = 0; nextClr = 0; kbBad = 0; postCycles = 0; done = 0;
      @(posedge clk);
      #1 bus.clearStart = 1'b1;
      for (int cyc = 0; cyc < 45000 && !done; cyc++) begin
        @(posedge clk);
        #1;
        bus.clearStart = 1'b0;
        if (cyc == 0) begin
          bus.cpuWrite = 1'b1; bus.cpuAddr = 16'h3000; bus.cpuColor = 3'd2;
          bus.kbValid = 1'b1;  bus.kbAddr = 16'h0BBB;  bus.kbColor = 3'd6;
        end else if (cyc == 1) begin
          bus.cpuAddr = 16'h3001; bus.cpuColor = 3'd3;
        end else if (cyc == 2) begin
          bus.cpuWrite = 1'b0;
          bus.clearStart = 1'b1;
        end
        @(negedge clk);
        if (bus.clearBusy) begin
          busyCycles++;
          if (bus.kbReady) kbBad++;
        end else if (busyCycles > 0) begin
          postCycles++;
          if (postCycles >= 6) done = 1;
        end
        if (bus.writeEnable) begin
          if (nextClr < 39936 && bus.writeAddress == 16'(nextClr) && bus.dataIn == 3'b000) begin
            nextClr++;
          end else begin
            otherAddr.push_back(bus.writeAddress);
            otherData.push_back(bus.dataIn);
          end
        end
      end
      bus.kbValid = 1'b0;
      checkOutput("clear busy cycles", 32'(busyCycles), 32'd39936);
      checkOutput("clear addresses", 32'(nextClr), 32'd39936);
      checkOutput("clear kb ready", 32'(kbBad), 32'd0);
      checkOutput("drain count", 32'(otherAddr.size() >= 3), 32'd1);
      checkOutput("drain0 addr", 32'(otherAddr.size() > 0 ? otherAddr[0] : 16'hFFFF), 32'h3000);
      checkOutput("drain0 data", 32'(otherData.size() > 0 ? otherData[0] : 3'd7), 32'd2);
      checkOutput("drain1 addr", 32'(otherAddr.size() > 1 ? otherAddr[1] : 16'hFFFF), 32'h0BBB);
      checkOutput("drain2 addr", 32'(otherAddr.size() > 2 ? otherAddr[2] : 16'hFFFF), 32'h3001);
      checkOutput("drain2 data", 32'(otherData.size() > 2 ? otherData[2] : 3'd7), 32'd3);
    end
`else
    @(posedge clk);
    #1 bus.clearStart = 1'b1;
    @(posedge clk);
    #1 bus.clearStart = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("noclear%0d busy", i), 32'(bus.clearBusy), 32'd0);
      checkOutput($sformatf("noclear%0d we", i), 32'(bus.writeEnable), 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
